// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request/result bundle between control/regfile and the mult/div unit
interface mult_div_unit_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  modport master (output start, op, rs_data, rt_data, input busy, done, hi, lo);
  modport slave (input start, op, rs_data, rt_data, output busy, done, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MULT/MULTU/DIV/DIVU with architectural HI/LO registers
module mult_div_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] DIVZ_LO = {XLEN{1'b1}}
) (
  input logic clk,
  input logic reset,
  mult_div_unit_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_n;
  logic [CW-1:0] count;
  logic [XLEN-1:0] mcand, rs_raw, hi_r, lo_r, ma, mb, sub, q_fix, r_fix;
  logic [2*XLEN-1:0] acc, mul_next, div_next, prod;
  logic [XLEN:0] mul_sum, rem_sh;
  logic is_div, divz, neg_q, neg_r, sa, sb, done_r, accept;
  // Operands are iterated as magnitudes; signs are reapplied in FIX.
  always_comb begin
    accept = state == IDLE && bus.start && !bus.op[2];
    sa = !bus.op[0] && bus.rs_data[XLEN-1];
    sb = !bus.op[0] && bus.rt_data[XLEN-1];
    ma = sa ? -bus.rs_data : bus.rs_data;
    mb = sb ? -bus.rt_data : bus.rt_data;
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
    mul_next = {mul_sum, acc[XLEN-1:1]};
    rem_sh = acc[2*XLEN-1:XLEN-1];
    sub = rem_sh[XLEN-1:0] - mcand;
    div_next = rem_sh >= {1'b0, mcand} ? {sub, acc[XLEN-2:0], 1'b1}
                                       : {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    prod = neg_q ? -acc : acc;
    q_fix = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    r_fix = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state == IDLE ? (accept ? RUN : IDLE)
            : state == RUN  ? (count == CW'(XLEN-1) ? FIX : RUN)
            : IDLE;
  end
  always_comb begin
    bus.busy = state != IDLE;
    bus.done = done_r;
    bus.hi = hi_r;
    bus.lo = lo_r;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      acc <= '0;
      mcand <= '0;
      rs_raw <= '0;
      hi_r <= '0;
      lo_r <= '0;
      done_r <= 1'b0;
      is_div <= 1'b0;
      divz <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      done_r <= state == FIX;
      if (accept) begin
        is_div <= bus.op[1];
        divz <= bus.op[1] && bus.rt_data == '0;
        neg_q <= sa ^ sb;
        neg_r <= sa;
        mcand <= bus.op[1] ? mb : ma;
        acc <= {{XLEN{1'b0}}, bus.op[1] ? ma : mb};
        rs_raw <= bus.rs_data;
        count <= '0;
      end else if (state == IDLE && bus.start && bus.op == 3'd4) hi_r <= bus.rs_data;
      else if (state == IDLE && bus.start && bus.op == 3'd5) lo_r <= bus.rs_data;
      if (state == RUN) begin
        acc <= is_div ? div_next : mul_next;
        count <= count + CW'(1);
      end
      if (state == FIX) begin
        hi_r <= is_div ? (divz ? rs_raw : r_fix) : prod[2*XLEN-1:XLEN];
        lo_r <= is_div ? (divz ? DIVZ_LO : q_fix) : prod[XLEN-1:0];
      end
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench with an arithmetic reference model for mult_div_unit
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic [63:0] exp_q[$];
  int cyc_q[$];
  logic [63:0] mon_e;
  int mon_c;
  logic [2:0] r_op;
  logic [31:0] r_a, r_b;
  logic seen;

  mult_div_unit_if #(.XLEN(32)) bus();
  mult_div_unit #(.XLEN(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    int q, r;
    longint p;
    case (op)
      3'd0: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
      end
      3'd1: return {32'b0, a} * {32'b0, b};
      3'd2: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
      else begin
        mon_e = exp_q.pop_front();
        mon_c = cyc_q.pop_front();
        chk("result_hilo", {bus.hi, bus.lo}, mon_e);
        chk("done_latency", 64'(cyc - mon_c), 64'd33);
      end
    end
  end

  task automatic issue(logic [2:0] op, logic [31:0] rs, logic [31:0] rt);
    bus.start = 1'b1;
    bus.op = op;
    bus.rs_data = rs;
    bus.rt_data = rt;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    if (op < 3'd4) begin
      exp_q.push_back(model(op, rs, rt));
      cyc_q.push_back(cyc);
    end
  endtask

  // inj pulses ignored starts at busy cycles 5, 10 and in the FIX cycle (33)
  task automatic run_op(logic [2:0] op, logic [31:0] rs, logic [31:0] rt, bit inj);
    int n;
    n = 0;
    issue(op, rs, rt);
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      bus.start = inj && (n == 5 || n == 10 || n == 33);
      bus.op = n == 5 ? 3'd5 : n == 10 ? 3'd3 : 3'd4;
      bus.rs_data = n == 5 ? 32'hDEADBEEF : 32'h11111111;
      bus.rt_data = 32'h3;
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("busy_cycles", 64'(n), 64'd33);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.op = 3'd0;
    bus.rs_data = '0;
    bus.rt_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("reset_busy_done", 64'({bus.busy, bus.done}), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    run_op(3'd0, 32'hFFFFFFFD, 32'd7, 1'b0);
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    run_op(3'd3, 32'd100, 32'd0, 1'b0);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_op(3'd2, 32'h00000007, 32'hFFFFFFFE, 1'b0);
    issue(3'd4, 32'h12345678, 32'd0);
    chk("mthi_hi", 64'(bus.hi), 64'h12345678);
    chk("mthi_busy_done", 64'({bus.busy, bus.done}), 64'd0);
    issue(3'd5, 32'h9ABCDEF0, 32'd0);
    chk("mtlo_hilo", {bus.hi, bus.lo}, 64'h12345678_9ABCDEF0);
    chk("mtlo_busy_done", 64'({bus.busy, bus.done}), 64'd0);
    issue(3'd6, 32'h55555555, 32'd1);
    chk("noop_op6", {31'd0, bus.busy, bus.hi, bus.lo}, 64'h12345678_9ABCDEF0);
    run_op(3'd0, 32'h00012345, 32'hFFFFFFB3, 1'b1);
    issue(3'd3, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    exp_q.delete();
    cyc_q.delete();
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    run_op(3'd1, 32'd6, 32'd7, 1'b0);
    for (int i = 0; i < 30; i++) begin
      r_op = 3'($urandom_range(0, 3));
      r_a = $urandom;
      r_b = $urandom;
      case ($urandom_range(0, 7))
        0: r_b = 32'd0;
        1: begin
          r_a = 32'h80000000;
          r_b = 32'hFFFFFFFF;
        end
        2: begin
          r_a = $urandom_range(0, 100);
          r_b = $urandom_range(1, 10);
        end
        default: ;
      endcase
      run_op(r_op, r_a, r_b, 1'b0);
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
